// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: arbiter states, reset constants and the memory window range check.
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} arb_state_t;

    localparam logic [31:0] RDATA_ZERO = 32'h0;

    // 33-bit compare keeps base + size from wrapping at the top of the address space
    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base, input logic [32:0] size);
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < {1'b0, base} + size);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshake plus DataMemory strobe bus for dmem_arbiter.
interface dmem_arbiter_if #(parameter int NREQ = 2);

    logic [NREQ-1:0]       REQ;
    logic [NREQ-1:0]       REQ_WE;
    logic [NREQ-1:0][31:0] REQ_ADDR;
    logic [NREQ-1:0][31:0] REQ_WDATA;
    logic [NREQ-1:0]       GNT;
    logic [NREQ-1:0]       RSP_VALID;
    logic [31:0]           RSP_RDATA;
    logic                  RSP_ERR;
    logic                  MEM_RDSTB;
    logic                  MEM_WRSTB;
    logic [31:0]           MEM_ADDR;
    logic [31:0]           MEM_WDATA;
    logic [31:0]           MEM_RDATA;

    modport slave (
        input  REQ, REQ_WE, REQ_ADDR, REQ_WDATA, MEM_RDATA,
        output GNT, RSP_VALID, RSP_RDATA, RSP_ERR, MEM_RDSTB, MEM_WRSTB, MEM_ADDR, MEM_WDATA
    );

    modport master (
        output REQ, REQ_WE, REQ_ADDR, REQ_WDATA, MEM_RDATA,
        input  GNT, RSP_VALID, RSP_RDATA, RSP_ERR, MEM_RDSTB, MEM_WRSTB, MEM_ADDR, MEM_WDATA
    );

endinterface

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter: one-hot round-robin winner; the last served requester has lowest priority.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [NREQ-1:0]         i_req,
    input  logic                    i_en,
    output logic [NREQ-1:0]         o_gnt,
    output logic [$clog2(NREQ)-1:0] o_win
);

    localparam int W = $clog2(NREQ);

    logic [W-1:0] r_last;
    logic [W-1:0] w_idx;

    // scan farthest-first so the nearest requester after r_last overrides
    always_comb begin
        o_gnt = '0;
        o_win = '0;
        w_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = W'((int'(r_last) + k) % NREQ);
            if (i_req[w_idx]) begin
                o_gnt        = '0;
                o_gnt[w_idx] = 1'b1;
                o_win        = w_idx;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET)
        if (ARESET)
            r_last <= W'(NREQ - 1);
        else if (i_en)
            r_last <= o_win;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port DataMemory among NREQ requesters,
// one transaction in flight, out-of-range addresses answered locally with an error.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int          NREQ        = 2,
    parameter int          DMSIZE      = 1024,
    parameter logic [31:0] BASEADDRESS = 32'h0000_0000
) (
    input logic          ACLK,
    input logic          ARESET,
    dmem_arbiter_if.slave bus
);

    localparam int W = $clog2(NREQ);

    arb_state_t      r_state, w_next;
    logic [W-1:0]    r_win, w_win;
    logic [NREQ-1:0] w_arb_gnt;
    logic            r_err;
    logic [31:0]     r_rdata;
    logic [31:0]     w_addr;
    logic            w_we, w_ok, w_acc, w_rd, w_wr;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .i_req  (bus.REQ),
        .i_en   (w_acc),
        .o_gnt  (w_arb_gnt),
        .o_win  (w_win)
    );

    assign w_addr = bus.REQ_ADDR[w_win];
    assign w_we   = bus.REQ_WE[w_win];
    assign w_ok   = in_range(w_addr, BASEADDRESS, 33'(DMSIZE));
    // gating with ARESET keeps every combinational output low while reset is held
    assign w_acc  = (r_state == IDLE) && (|bus.REQ) && !ARESET;
    assign w_rd   = w_acc && w_ok && !w_we;
    assign w_wr   = w_acc && w_ok && w_we;

    always_comb begin
        w_next        = r_state == IDLE    ? (w_acc ? (w_rd ? RD_WAIT : RESP) : IDLE) :
                        r_state == RD_WAIT ? RESP : IDLE;
        bus.GNT       = w_acc ? w_arb_gnt : '0;
        bus.MEM_RDSTB = w_rd;
        bus.MEM_WRSTB = w_wr;
        bus.MEM_ADDR  = (w_rd || w_wr) ? w_addr : '0;
        bus.MEM_WDATA = w_wr ? bus.REQ_WDATA[w_win] : '0;
        bus.RSP_VALID = r_state == RESP ? NREQ'(1) << r_win : '0;
        bus.RSP_ERR   = (r_state == RESP) && r_err;
        bus.RSP_RDATA = r_rdata;
    end

    // r_rdata only moves into a response cycle, so it holds between responses
    always_ff @(posedge ACLK or posedge ARESET)
        if (ARESET) begin
            r_state <= IDLE;
            r_win   <= '0;
            r_err   <= 1'b0;
            r_rdata <= RDATA_ZERO;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_win <= w_win;
                r_err <= !w_ok;
                if (!w_rd)
                    r_rdata <= RDATA_ZERO;
            end
            if (r_state == RD_WAIT)
                r_rdata <= bus.MEM_RDATA;
        end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench with a DataMemory model and a round-robin reference.
module tb_dmem_arbiter;

    localparam int NREQ   = 3;
    localparam int DMSIZE = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.NREQ(NREQ)) bus ();
    dmem_arbiter_if #(.NREQ(2))    bus2 ();

    dmem_arbiter #(.NREQ(NREQ), .DMSIZE(DMSIZE), .BASEADDRESS(32'h0000_0000)) dut (
        .ACLK(clk), .ARESET(rst), .bus(bus)
    );

    dmem_arbiter #(.NREQ(2), .DMSIZE(1024), .BASEADDRESS(32'hFFFF_FC00)) dut2 (
        .ACLK(clk), .ARESET(rst2), .bus(bus2)
    );

    typedef struct {
        int          id;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } rsp_t;

    int              errors = 0;
    int              checks = 0;
    int              cyc = 0;
    rsp_t            q[$];
    logic [31:0]     dm [DMSIZE];
    logic [31:0]     ref_mem [DMSIZE];
    logic [31:0]     rd_q = '0;
    logic            rd_v = 1'b0;
    logic [31:0]     noise = '0;
    int              m_busy = 0;
    int              m_last = NREQ - 1;
    logic [31:0]     hold_rdata = '0;
    logic [NREQ-1:0] g_seen = '0;
    logic [31:0]     b_addr [4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FBFF, 32'hFFFF_FC00};
    logic            b_err  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    function automatic logic [31:0] pat(int i);
        return 32'(i) * 32'h0101_0003 + 32'h77;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // DataMemory stand-in: registered read, data only valid the cycle after RDSTB
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.MEM_WRSTB) dm[bus.MEM_ADDR[9:0]] <= bus.MEM_WDATA;
        rd_v <= bus.MEM_RDSTB;
        if (bus.MEM_RDSTB) rd_q <= dm[bus.MEM_ADDR[9:0]];
        noise <= ($urandom_range(0, 1) == 0) ? 32'hzzzz_zzzz : $urandom;
    end
    assign bus.MEM_RDATA  = rd_v ? rd_q : noise;
    assign bus2.MEM_RDATA = 32'h0;

    // reference model: grant decision, memory effects and expected responses
    always @(negedge clk) begin : model
        int w, idx;
        logic [31:0] a;
        logic ok, rd;
        if (rst) begin
            chk("rst_gnt", 32'(bus.GNT), 0);
            chk("rst_rsp_valid", 32'(bus.RSP_VALID), 0);
            chk("rst_strobes", {30'b0, bus.MEM_RDSTB, bus.MEM_WRSTB}, 0);
            chk("rst_mem_addr", bus.MEM_ADDR, 0);
            chk("rst_rdata", bus.RSP_RDATA, 0);
            q.delete();
            m_busy = 0;
            m_last = NREQ - 1;
            hold_rdata = '0;
            g_seen = '0;
        end else begin
            if (m_busy > 0) m_busy--;
            w = -1;
            if (m_busy == 0)
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_last + k) % NREQ;
                    if (w < 0 && bus.REQ[idx]) w = idx;
                end
            chk("gnt", 32'(bus.GNT), w < 0 ? 0 : 1 << w);
            g_seen = bus.GNT;
            if (w >= 0) begin
                a  = bus.REQ_ADDR[w];
                ok = a < 32'(DMSIZE);
                rd = ok && !bus.REQ_WE[w];
                chk("mem_rdstb", 32'(bus.MEM_RDSTB), 32'(rd));
                chk("mem_wrstb", 32'(bus.MEM_WRSTB), 32'(ok && bus.REQ_WE[w]));
                chk("mem_addr", bus.MEM_ADDR, ok ? a : 0);
                if (ok && bus.REQ_WE[w]) begin
                    chk("mem_wdata", bus.MEM_WDATA, bus.REQ_WDATA[w]);
                    ref_mem[a[9:0]] = bus.REQ_WDATA[w];
                end
                q.push_back(rsp_t'{id: w, err: !ok, rdata: rd ? ref_mem[a[9:0]] : 32'h0, due: cyc + (rd ? 2 : 1)});
                m_last = w;
                m_busy = rd ? 3 : 2;
            end else
                chk("idle_strobes", {30'b0, bus.MEM_RDSTB, bus.MEM_WRSTB}, 0);
        end
    end

    // response monitor
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (!rst) begin
            if (bus.RSP_VALID != '0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got RSP_VALID=%b with nothing outstanding (cycle %0d)", bus.RSP_VALID, cyc);
                end else begin
                    e = q.pop_front();
                    chk("rsp_id", 32'(bus.RSP_VALID), 1 << e.id);
                    chk("rsp_err", 32'(bus.RSP_ERR), 32'(e.err));
                    chk("rsp_rdata", bus.RSP_RDATA, e.rdata);
                    chk("rsp_latency", cyc, e.due);
                    hold_rdata = e.rdata;
                end
            end else begin
                chk("rdata_hold", bus.RSP_RDATA, hold_rdata);
                chk("err_idle", 32'(bus.RSP_ERR), 0);
            end
        end
    end

    task automatic issue(int i, logic we, logic [31:0] a, logic [31:0] d);
        bus.REQ[i]       = 1'b1;
        bus.REQ_WE[i]    = we;
        bus.REQ_ADDR[i]  = a;
        bus.REQ_WDATA[i] = d;
    endtask

    task automatic wait_gnt(int i, output logic got);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = bus.GNT[i];
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: requester %0d got no GNT in 20 cycles", i);
        end
    endtask

    task automatic txn(string nm, int i, logic we, logic [31:0] a, logic [31:0] d, logic err, logic [31:0] rdata);
        logic got;
        logic seen;
        issue(i, we, a, d);
        wait_gnt(i, got);
        step();
        bus.REQ[i] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 6 && got && !seen; n++) begin
            if (n > 0) @(negedge clk);
            else @(negedge clk);
            if (bus.RSP_VALID[i]) begin
                seen = 1'b1;
                chk({nm, "_err"}, 32'(bus.RSP_ERR), 32'(err));
                chk({nm, "_rdata"}, bus.RSP_RDATA, rdata);
            end
        end
        if (got && !seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no RSP_VALID for requester %0d", nm, i);
        end
        step();
    endtask

    task automatic rand_req(int i);
        int sel;
        logic [31:0] a;
        sel = $urandom_range(0, 3);
        a = sel == 0 ? $urandom : sel == 1 ? 32'(1020 + $urandom_range(0, 7)) : 32'($urandom_range(0, DMSIZE - 1));
        issue(i, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    initial begin : main
        int gc[$];
        int gi[$];
        logic got;
        for (int i = 0; i < DMSIZE; i++) begin
            dm[i] = pat(i);
            ref_mem[i] = pat(i);
        end
        bus.REQ = '0;
        bus.REQ_WE = '0;
        bus.REQ_ADDR = '0;
        bus.REQ_WDATA = '0;
        repeat (3) step();
        rst = 1'b0;

        // continuous reads from 0 and 1: alternate, 3 cycles apart, 0 first
        issue(0, 1'b0, 32'd10, 32'h0);
        issue(1, 1'b0, 32'd11, 32'h0);
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (bus.GNT != '0) begin
                gi.push_back(int'(bus.GNT));
                gc.push_back(cyc);
            end
        end
        step();
        bus.REQ = '0;
        chk("rr_count", 32'(gi.size() >= 4), 1);
        for (int k = 0; k < 4 && k < gi.size(); k++) begin
            chk("rr_order", 32'(gi[k]), (k % 2) ? 2 : 1);
            if (k > 0) chk("rr_gap", 32'(gc[k] - gc[k-1]), 3);
        end
        repeat (4) step();

        txn("wr_beef", 0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 32'h0);
        txn("rd_beef", 0, 1'b0, 32'd5, 32'h0, 1'b0, 32'hDEAD_BEEF);
        txn("oor_1024", 1, 1'b0, 32'd1024, 32'h0, 1'b1, 32'h0);
        txn("ok_1023", 1, 1'b0, 32'd1023, 32'h0, 1'b0, pat(1023));

        // reset while a read sits in RD_WAIT
        issue(0, 1'b0, 32'd7, 32'h0);
        wait_gnt(0, got);
        step();
        rst = 1'b1;
        bus.REQ[0] = 1'b0;
        issue(1, 1'b0, 32'd9, 32'h0);
        #1;
        chk("rst_mid_rsp", 32'(bus.RSP_VALID), 0);
        chk("rst_mid_gnt", 32'(bus.GNT), 0);
        chk("rst_mid_rdstb", 32'(bus.MEM_RDSTB), 0);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("gnt_after_rst", 32'(bus.GNT), 2);
        step();
        bus.REQ[1] = 1'b0;
        repeat (4) step();

        // req0 withdraws while req1 is being served
        issue(1, 1'b0, 32'd20, 32'h0);
        wait_gnt(1, got);
        step();
        bus.REQ[1] = 1'b0;
        issue(0, 1'b0, 32'd30, 32'h0);
        @(negedge clk);
        chk("drop_gnt_rdwait", 32'(bus.GNT[0]), 0);
        step();
        bus.REQ[0] = 1'b0;
        @(negedge clk);
        chk("drop_gnt_resp", 32'(bus.GNT[0]), 0);
        step();
        @(negedge clk);
        chk("drop_gnt_idle", 32'(bus.GNT), 0);
        repeat (3) step();

        for (int n = 0; n < 3000; n++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (bus.REQ[i] && (g_seen[i] || $urandom_range(0, 15) == 0)) bus.REQ[i] = 1'b0;
                if (!bus.REQ[i] && $urandom_range(0, 2) == 0) rand_req(i);
            end
        end
        step();
        bus.REQ = '0;
        repeat (10) step();
        chk("drain", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // instance at the top of the address space: in-range check must not wrap
    initial begin : top_window
        bus2.REQ = '0;
        bus2.REQ_WE = '0;
        bus2.REQ_ADDR = '0;
        bus2.REQ_WDATA = '0;
        repeat (2) step();
        rst2 = 1'b0;
        for (int t = 0; t < 4; t++) begin
            step();
            bus2.REQ[0] = 1'b1;
            bus2.REQ_WE[0] = 1'b1;
            bus2.REQ_ADDR[0] = b_addr[t];
            bus2.REQ_WDATA[0] = 32'(t + 1);
            @(negedge clk);
            chk("top_gnt", 32'(bus2.GNT), 1);
            chk("top_wrstb", 32'(bus2.MEM_WRSTB), 32'(!b_err[t]));
            chk("top_mem_addr", bus2.MEM_ADDR, b_err[t] ? 32'h0 : b_addr[t]);
            step();
            bus2.REQ[0] = 1'b0;
            @(negedge clk);
            chk("top_rsp_valid", 32'(bus2.RSP_VALID), 1);
            chk("top_rsp_err", 32'(bus2.RSP_ERR), 32'(b_err[t]));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
